// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 VGA timing constants and the coordinate type used by the
// sync generator and the overlay / colour-mux blocks.
//   - *_DEF     : default visible/porch/sync sizes (pixels or lines)
//   - H_TOTAL / V_TOTAL : full line / frame length for the defaults
//   - *_SYNC_START / *_SYNC_END : inclusive sync-low windows for the defaults
//   - coord_t   : 10-bit pixel coordinate
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISP_DEF = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_DISP_DEF = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOTAL = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_DISP_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISP_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock into a one-clock-wide pixel enable.
//   clk    : system clock
//   reset  : asynchronous active-high reset (counter returns to 0)
//   p_tick : high for one clk every DIV clocks (constantly high when DIV == 1)
// -----------------------------------------------------------------------------
module pixel_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  // Keep at least one bit so DIV == 1 still elaborates; the counter then
  // sits at 0 == DIV-1 and p_tick stays high.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (div_cnt_q == LAST) div_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

  assign p_tick = (div_cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Pixel-timing generator for the 640x480 VGA path. All outputs are aligned so
// downstream logic samples pixel_x/pixel_y/video_on on the same p_tick.
//   clk        : system clock (DIV clocks per pixel)
//   reset      : asynchronous active-high reset
//   p_tick     : pixel enable, one clk every DIV clocks
//   hsync      : horizontal sync, active low
//   vsync      : vertical sync, active low
//   video_on   : current coordinate is inside the visible area
//   pixel_x    : horizontal count 0..H_TOTAL-1
//   pixel_y    : vertical count 0..V_TOTAL-1
//   frame_tick : (only with VGA_SYNC_FRAME_TICK_EN defined) one-clk pulse on
//                the edge where the counters wrap to (0, 0)
// Build option: define VGA_SYNC_FRAME_TICK_EN to add the frame_tick output.
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int DIV    = 2,
  parameter int H_DISP = H_DISP_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic               frame_tick
`endif
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISP);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISP);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISP + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISP + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISP + V_FP + V_SYNC - 1);

  // Elaboration-time legality checks: counters are 10 bits wide.
  if (H_TOT > 1023) begin : g_bad_h_total
    $error("vga_sync_gen: horizontal total %0d exceeds 1023", H_TOT);
  end
  if (V_TOT > 1023) begin : g_bad_v_total
    $error("vga_sync_gen: vertical total %0d exceeds 1023", V_TOT);
  end
  if (DIV < 1 || DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: DIV %0d outside 1..16", DIV);
  end

  pixel_tick_gen #(.DIV(DIV)) u_pixel_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_wrap;

  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d    = '0;
          frame_wrap = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
    // Syncs decode the next counts so they change on the same edge as the
    // counters, giving zero skew to pixel_x/pixel_y.
    hsync_d = !((h_cnt_d >= HS_START) && (h_cnt_d <= HS_END));
    vsync_d = !((v_cnt_d >= VS_START) && (v_cnt_d <= VS_END));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  assign frame_tick_d = frame_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_tick_q <= 1'b0;
    else       frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign pixel_x  = h_cnt_q;
  assign pixel_y  = v_cnt_q;

endmodule
